// File: rtl/compositor_pkg.sv
// Shared types and helpers for the layered RGB compositor.
// Optional collision reporting is enabled with the COMPOSITOR_COLLISION_EN macro.
package compositor_pkg;

  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb24_t;

  localparam rgb332_t TRANSPARENT_RGB_DEFAULT = 8'hFF;

  // Replicate each field's LSB so full-scale RGB332 maps to 8'hFF.
  function automatic rgb24_t rgb332_expand(input rgb332_t c);
    rgb24_t x;
    x.red   = {c[7:5], {5{c[5]}}};
    x.green = {c[4:2], {5{c[2]}}};
    x.blue  = {c[1:0], {6{c[0]}}};
    return x;
  endfunction

endpackage

// File: rtl/compositor_prio_table.sv
// Shadow/active priority table and enable mask with frame-aligned commit.
// Part of the compositor slice; see COMPOSITOR_COLLISION_EN in the top level.
module compositor_prio_table
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frameStart,
  input  logic                        cfgPrioWrite,
  input  logic [IDX_W-1:0]            cfgRank,
  input  logic [IDX_W-1:0]            cfgLayer,
  input  logic                        cfgMaskWrite,
  input  logic [NUM_LAYERS-1:0]       cfgMask,
  output logic [NUM_LAYERS*IDX_W-1:0] activePrio,
  output logic [NUM_LAYERS-1:0]       activeMask
);

  logic [IDX_W-1:0]      shadowPrio     [NUM_LAYERS];
  logic [IDX_W-1:0]      shadowPrioNext [NUM_LAYERS];
  logic [IDX_W-1:0]      activePrioArr  [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] shadowMask;
  logic [NUM_LAYERS-1:0] shadowMaskNext;
  logic                  prioWriteOk;

  // Out-of-range ranks or layers only exist for non-power-of-2 sizes; drop them.
  assign prioWriteOk = cfgPrioWrite
                     && (int'(cfgRank) < NUM_LAYERS)
                     && (int'(cfgLayer) < NUM_LAYERS);

  always_comb begin
    for (int r = 0; r < NUM_LAYERS; r++) begin
      shadowPrioNext[r] = shadowPrio[r];
      if (prioWriteOk && (cfgRank == IDX_W'(r)))
        shadowPrioNext[r] = cfgLayer;
    end
    shadowMaskNext = cfgMaskWrite ? cfgMask : shadowMask;
  end

  // Commit copies the post-write shadow, so a write in the frameStart cycle lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_LAYERS; r++) begin
        shadowPrio[r]    <= IDX_W'(r);
        activePrioArr[r] <= IDX_W'(r);
      end
      shadowMask <= '1;
      activeMask <= '1;
    end else begin
      for (int r = 0; r < NUM_LAYERS; r++) begin
        shadowPrio[r] <= shadowPrioNext[r];
        if (frameStart)
          activePrioArr[r] <= shadowPrioNext[r];
      end
      shadowMask <= shadowMaskNext;
      if (frameStart)
        activeMask <= shadowMaskNext;
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_flat
    assign activePrio[g*IDX_W +: IDX_W] = activePrioArr[g];
  end

endmodule

// File: rtl/layered_rgb_compositor.sv
// Priority-table RGB332 layer compositor with 2-stage pipeline to 24-bit RGB.
// Define COMPOSITOR_COLLISION_EN to add collisionOut / collisionMask.
module layered_rgb_compositor
  import compositor_pkg::*;
#(
  parameter int      NUM_LAYERS      = 8,
  parameter int      IDX_W           = $clog2(NUM_LAYERS),
  parameter rgb332_t TRANSPARENT_RGB = TRANSPARENT_RGB_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frameStart,
  input  logic                      pixelValidIn,
  input  logic [NUM_LAYERS-1:0]     drawingRequest,
  input  logic [NUM_LAYERS*8-1:0]   layerRGB,
  input  logic [7:0]                backGroundRGB,
  input  logic                      cfgPrioWrite,
  input  logic [IDX_W-1:0]          cfgRank,
  input  logic [IDX_W-1:0]          cfgLayer,
  input  logic                      cfgMaskWrite,
  input  logic [NUM_LAYERS-1:0]     cfgMask,
  output logic [7:0]                redOut,
  output logic [7:0]                greenOut,
  output logic [7:0]                blueOut,
  output logic                      pixelValidOut,
  output logic [IDX_W-1:0]          winnerIdx,
`ifdef COMPOSITOR_COLLISION_EN
  output logic                      collisionOut,
  output logic [NUM_LAYERS-1:0]     collisionMask,
`endif
  output logic                      winnerHit
);

  logic [NUM_LAYERS*IDX_W-1:0] activePrio;
  logic [NUM_LAYERS-1:0]       activeMask;
  logic [IDX_W-1:0]            prioArr  [NUM_LAYERS];
  rgb332_t                     layerArr [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]       cand;

  rgb332_t                     selRGB;
  logic [IDX_W-1:0]            selIdx;
  logic                        selHit;

  rgb332_t                     s1RGB;
  logic [IDX_W-1:0]            s1Idx;
  logic                        s1Hit;
  logic                        s1Valid;
  rgb24_t                      expanded;

  compositor_prio_table #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_prio_table (
    .clk          (clk),
    .reset        (reset),
    .frameStart   (frameStart),
    .cfgPrioWrite (cfgPrioWrite),
    .cfgRank      (cfgRank),
    .cfgLayer     (cfgLayer),
    .cfgMaskWrite (cfgMaskWrite),
    .cfgMask      (cfgMask),
    .activePrio   (activePrio),
    .activeMask   (activeMask)
  );

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layers
    assign prioArr[g]  = activePrio[g*IDX_W +: IDX_W];
    assign layerArr[g] = layerRGB[g*8 +: 8];
    assign cand[g]     = drawingRequest[g] & activeMask[g]
                       & (layerRGB[g*8 +: 8] != TRANSPARENT_RGB);
  end

  // First rank whose layer is a candidate wins; blanking forces everything to 0.
  always_comb begin
    logic found;
    found  = 1'b0;
    selRGB = backGroundRGB;
    selIdx = '0;
    selHit = 1'b0;
    for (int r = 0; r < NUM_LAYERS; r++) begin
      if (!found && cand[prioArr[r]]) begin
        found  = 1'b1;
        selRGB = layerArr[prioArr[r]];
        selIdx = prioArr[r];
        selHit = 1'b1;
      end
    end
    if (!pixelValidIn) begin
      selRGB = '0;
      selIdx = '0;
      selHit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1RGB   <= '0;
      s1Idx   <= '0;
      s1Hit   <= 1'b0;
      s1Valid <= 1'b0;
    end else begin
      s1RGB   <= selRGB;
      s1Idx   <= selIdx;
      s1Hit   <= selHit;
      s1Valid <= pixelValidIn;
    end
  end

  assign expanded = rgb332_expand(s1RGB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redOut        <= '0;
      greenOut      <= '0;
      blueOut       <= '0;
      winnerIdx     <= '0;
      winnerHit     <= 1'b0;
      pixelValidOut <= 1'b0;
    end else begin
      redOut        <= expanded.red;
      greenOut      <= expanded.green;
      blueOut       <= expanded.blue;
      winnerIdx     <= s1Idx;
      winnerHit     <= s1Hit;
      pixelValidOut <= s1Valid;
    end
  end

`ifdef COMPOSITOR_COLLISION_EN
  logic collNow;
  logic s1Coll;

  // Two or more set bits: clearing the lowest set bit leaves something behind.
  assign collNow = pixelValidIn && ((cand & (cand - NUM_LAYERS'(1))) != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Coll        <= 1'b0;
      collisionOut  <= 1'b0;
      collisionMask <= '0;
    end else begin
      s1Coll       <= collNow;
      collisionOut <= s1Coll;
      if (frameStart)
        collisionMask <= collNow ? cand : '0;
      else if (collNow)
        collisionMask <= collisionMask | cand;
    end
  end
`endif

endmodule

// File: tb/tb_layered_rgb_compositor.sv
// Directed self-checking bench for layered_rgb_compositor (NUM_LAYERS = 8).
// Collision checks are compiled in when COMPOSITOR_COLLISION_EN is defined.
module tb_layered_rgb_compositor;

  localparam int NL = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          frameStart;
  logic          pixelValidIn;
  logic [NL-1:0] drawingRequest;
  logic [NL*8-1:0] layerRGB;
  logic [7:0]    backGroundRGB;
  logic          cfgPrioWrite;
  logic [IW-1:0] cfgRank;
  logic [IW-1:0] cfgLayer;
  logic          cfgMaskWrite;
  logic [NL-1:0] cfgMask;
  logic [7:0]    redOut;
  logic [7:0]    greenOut;
  logic [7:0]    blueOut;
  logic          pixelValidOut;
  logic [IW-1:0] winnerIdx;
  logic          winnerHit;
`ifdef COMPOSITOR_COLLISION_EN
  logic          collisionOut;
  logic [NL-1:0] collisionMask;
`endif

  int checks = 0;
  int errors = 0;

  layered_rgb_compositor #(.NUM_LAYERS(NL)) dut (
    .clk            (clk),
    .reset          (reset),
    .frameStart     (frameStart),
    .pixelValidIn   (pixelValidIn),
    .drawingRequest (drawingRequest),
    .layerRGB       (layerRGB),
    .backGroundRGB  (backGroundRGB),
    .cfgPrioWrite   (cfgPrioWrite),
    .cfgRank        (cfgRank),
    .cfgLayer       (cfgLayer),
    .cfgMaskWrite   (cfgMaskWrite),
    .cfgMask        (cfgMask),
    .redOut         (redOut),
    .greenOut       (greenOut),
    .blueOut        (blueOut),
    .pixelValidOut  (pixelValidOut),
    .winnerIdx      (winnerIdx),
`ifdef COMPOSITOR_COLLISION_EN
    .collisionOut   (collisionOut),
    .collisionMask  (collisionMask),
`endif
    .winnerHit      (winnerHit)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [NL-1:0] req, input logic [7:0] bg);
    pixelValidIn   = valid;
    drawingRequest = req;
    backGroundRGB  = bg;
  endtask

  task automatic setLayer(input int i, input logic [7:0] rgb);
    layerRGB[i*8 +: 8] = rgb;
  endtask

  task automatic checkPixel(input string tag, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [IW-1:0] idx, input logic hit);
    checkOutput({tag, ".red"},   {24'h0, redOut},   {24'h0, r});
    checkOutput({tag, ".green"}, {24'h0, greenOut}, {24'h0, g});
    checkOutput({tag, ".blue"},  {24'h0, blueOut},  {24'h0, b});
    checkOutput({tag, ".idx"},   {29'h0, winnerIdx}, {29'h0, idx});
    checkOutput({tag, ".hit"},   {31'h0, winnerHit}, {31'h0, hit});
  endtask

  task automatic writePrio(input logic [IW-1:0] rank, input logic [IW-1:0] layer, input logic commit);
    cfgPrioWrite = 1'b1;
    cfgRank      = rank;
    cfgLayer     = layer;
    frameStart   = commit;
    tick();
    cfgPrioWrite = 1'b0;
    frameStart   = 1'b0;
  endtask

  task automatic writeMask(input logic [NL-1:0] m, input logic commit);
    cfgMaskWrite = 1'b1;
    cfgMask      = m;
    frameStart   = commit;
    tick();
    cfgMaskWrite = 1'b0;
    frameStart   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frameStart = 1'b0;
    cfgPrioWrite = 1'b0;
    cfgRank = '0;
    cfgLayer = '0;
    cfgMaskWrite = 1'b0;
    cfgMask = '0;
    layerRGB = '0;
    applyStimulus(1'b0, '0, 8'h00);
    tick();
    tick();
    checkPixel("reset", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    checkOutput("reset.valid", {31'h0, pixelValidOut}, 32'h0);

    // Identity table: layer 2 beats layer 5.
    setLayer(2, 8'hE0);
    setLayer(5, 8'h1C);
    applyStimulus(1'b1, 8'b0010_0100, 8'h00);
    reset = 1'b0;
    tick();
    checkOutput("latency1.valid", {31'h0, pixelValidOut}, 32'h0);
    checkOutput("latency1.hit",   {31'h0, winnerHit},     32'h0);
    tick();
    checkPixel("identity", 8'hFF, 8'h00, 8'h00, 3'd2, 1'b1);
    checkOutput("identity.valid", {31'h0, pixelValidOut}, 32'h1);

    // Shadow write alone must not change the picture.
    writePrio(3'd0, 3'd5, 1'b0);
    tick();
    tick();
    checkPixel("shadowOnly", 8'hFF, 8'h00, 8'h00, 3'd2, 1'b1);

    // Pixel sampled in the commit cycle still uses the old table.
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    tick();
    checkOutput("commitEdge.idx", {29'h0, winnerIdx}, 32'd2);
    tick();
    checkPixel("committed", 8'h00, 8'hFF, 8'h00, 3'd5, 1'b1);

    // Layer 2 transparent, layer 5 masked off -> background.
    setLayer(2, 8'hFF);
    applyStimulus(1'b1, 8'b0010_0100, 8'h03);
    writeMask(8'b1101_1111, 1'b0);
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    tick();
    tick();
    checkPixel("background", 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0);

    // Blanking forces black regardless of requests.
    setLayer(0, 8'hE0);
    applyStimulus(1'b0, 8'b0000_0001, 8'h03);
    tick();
    tick();
    checkPixel("blank", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    checkOutput("blank.valid", {31'h0, pixelValidOut}, 32'h0);

    // Layer 0 was displaced from rank 0, so it is absent from the table.
    applyStimulus(1'b1, 8'b0000_0001, 8'h03);
    tick();
    tick();
    checkPixel("absentLayer", 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0);

    // Priority write-through in the commit cycle places layer 0 at rank 1.
    writePrio(3'd1, 3'd0, 1'b1);
    tick();
    tick();
    checkPixel("prioWriteThrough", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1);

    // Mask write-through: all layers disabled from the next pixel.
    writeMask(8'h00, 1'b1);
    tick();
    tick();
    checkPixel("maskWriteThrough", 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0);

`ifdef COMPOSITOR_COLLISION_EN
    writeMask(8'hFF, 1'b1);
    setLayer(1, 8'h1C);
    setLayer(3, 8'h03);
    applyStimulus(1'b1, 8'b0000_1010, 8'h00);
    tick();
    applyStimulus(1'b1, 8'b0000_0000, 8'h00);
    checkOutput("coll.lat1", {31'h0, collisionOut}, 32'h0);
    tick();
    checkOutput("coll.pulse", {31'h0, collisionOut}, 32'h1);
    tick();
    checkOutput("coll.once", {31'h0, collisionOut}, 32'h0);
    checkOutput("coll.sticky", {24'h0, collisionMask}, 32'h0A);
    tick();
    checkOutput("coll.hold", {24'h0, collisionMask}, 32'h0A);
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    checkOutput("coll.clear", {24'h0, collisionMask}, 32'h00);
`endif

    // Reset mid-stream flushes outputs immediately and restores identity config.
    writeMask(8'hFF, 1'b1);
    setLayer(2, 8'hE0);
    setLayer(5, 8'h1C);
    applyStimulus(1'b1, 8'b0010_0100, 8'h00);
    tick();
    tick();
    checkOutput("preReset.hit", {31'h0, winnerHit}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkPixel("asyncReset", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    checkOutput("asyncReset.valid", {31'h0, pixelValidOut}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    checkPixel("postReset", 8'hFF, 8'h00, 8'h00, 3'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layered_rgb_compositor.md
Name: layered_rgb_compositor

Overview:
Parametrised successor to the fixed 8-layer VGA object priority mux. Selects one RGB332 pixel per clock from NUM_LAYERS drawing layers, using a runtime-programmable priority table, per-layer enable mask and transparent colour key, falling back to background. Output is a 2-stage pipeline expanded to 24-bit RGB, with matching sync/valid delay. Sits between the object drawers and the VGA controller.

Parameters:
NUM_LAYERS, 8, number of object layers (2..16)
IDX_W, $clog2(NUM_LAYERS), layer index / rank width (derived, not overridden)
TRANSPARENT_RGB, 8'hFF, layer colour treated as "not drawing"

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frameStart  in  1  one-cycle pulse at start of frame; commits shadow config
pixelValidIn  in  1  current pixel is in the active area
drawingRequest  in  NUM_LAYERS  per-layer draw request, bit i = layer i
layerRGB  in  NUM_LAYERS x 8  per-layer RGB332 colour
backGroundRGB  in  8  background colour
cfgPrioWrite  in  1  write pulse for one priority-table entry
cfgRank  in  IDX_W  rank to write (0 = highest priority)
cfgLayer  in  IDX_W  layer index placed at that rank
cfgMaskWrite  in  1  write pulse for enable mask
cfgMask  in  NUM_LAYERS  new enable mask
redOut  out  8  expanded red
greenOut  out  8  expanded green
blueOut  out  8  expanded blue
pixelValidOut  out  1  pixelValidIn delayed by 2
winnerIdx  out  IDX_W  selected layer index, aligned with RGB out
winnerHit  out  1  1 = a layer won, 0 = background, aligned with RGB out

Behaviour:
- Reset (async, active-high): all outputs 0; active and shadow prioTable[r]=r (identity); active and shadow mask all ones; pipeline regs 0.
- Config: cfgPrioWrite writes shadowPrio[cfgRank]=cfgLayer. cfgMaskWrite writes shadowMask. Writes never affect the active table directly.
- Commit: on a frameStart cycle, active table/mask <= shadow, including any write in that same cycle (write-through). The new config applies to pixels sampled from the next cycle onward.
- Candidate for layer i: drawingRequest[i] & activeMask[i] & (layerRGB[i] != TRANSPARENT_RGB).
- Stage 1 (registered): scan ranks 0..NUM_LAYERS-1. The first rank r whose layer prioTable[r] is a candidate wins: selRGB=layerRGB[L], selIdx=L, selHit=1. If none wins: selRGB=backGroundRGB, selIdx=0, selHit=0.
- If pixelValidIn=0: selRGB=0, selHit=0 (blanking forced black).
- Duplicate table entries are legal; the higher rank dominates. A layer absent from the table is never drawn.
- Stage 2 (registered): red={c[7:5],{5{c[5]}}}, green={c[4:2],{5{c[2]}}}, blue={c[1:0],{6{c[0]}}}. winnerIdx, winnerHit and pixelValidOut are delayed in lockstep.
- Latency: inputs at edge N appear on outputs after edge N+2. Throughput is 1 pixel/clk, with no stall.
- cfgRank/cfgLayer values >= NUM_LAYERS (non-power-of-2 sizes) are ignored on write.
- Reset mid-frame: pipeline flushes to 0 immediately; config returns to identity/all-enabled.

Optional Feature:
COMPOSITOR_COLLISION_EN. When defined, adds outputs collisionOut (1 bit) and collisionMask (NUM_LAYERS bits).
- collisionOut = 1 when two or more candidates exist on a valid pixel; aligned with RGB out.
- collisionMask is a sticky OR of the candidate vectors for all colliding pixels. It clears on frameStart; a collision in the same cycle as frameStart seeds the new value. It resets to 0.
When not defined, these ports and all their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package compositor_pkg: RGB332 typedef; rgb332_expand function returning the 24-bit struct; TRANSPARENT_RGB default constant.
- Sub-module compositor_prio_table: shadow/active table plus mask, write and commit logic, reset to identity. The top level holds the select and pipeline stages.

Test Plan:
- Reset, identity table; layers 2 and 5 request with RGB 8'hE0 and 8'h1C, valid=1 -> 2 clocks later red=8'hFF, green=0, blue=0, winnerIdx=2, winnerHit=1.
- Write rank0=5 with no frameStart -> output stays layer 2. Pulse frameStart -> next pixel gives green=8'hFF, winnerIdx=5.
- Layer 2 RGB=8'hFF (transparent), layer 5 masked off, background 8'h03 -> blue=8'hFF, winnerHit=0.
- pixelValidIn=0 with layer 0 requesting 8'hE0 -> outputs 0, winnerHit=0, pixelValidOut=0 two clocks later.
- Mask write 8'h00 in the same cycle as frameStart -> the next pixel is background (write-through commit).
- COLLISION_EN: layers 1 and 3 overlap on one pixel -> collisionOut=1 for one cycle, collisionMask=8'h0A until frameStart, then 0. Assert reset mid-stream -> all outputs 0 asynchronously.
